mdio_arbiter: RTL



---
 rtl/mdio_arbiter_if.sv | 26 ++
 rtl/mdio_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mdio_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_arbiter_if : per-lane request/response bus of the MDIO arbiter      |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
interface mdio_arbiter_if;
  logic [7:0]   req_i;
  logic [15:0]  cmd_op_i;
  logic [39:0]  cmd_devad_i;
  logic [127:0] cmd_data_i;
  logic [7:0]   gnt_o;
  logic [7:0]   rsp_valid_o;
  logic [15:0]  rsp_data_o;
  logic         busy_o;

  modport master (
    output req_i, cmd_op_i, cmd_devad_i, cmd_data_i,
    input  gnt_o, rsp_valid_o, rsp_data_o, busy_o
  );

  modport slave (
    input  req_i, cmd_op_i, cmd_devad_i, cmd_data_i,
    output gnt_o, rsp_valid_o, rsp_data_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/mdio_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdio_arbiter : round-robin clause-45 MDIO master shared by eight lanes   |
// | Option       : define MDIO_PREAMBLE_EN for a 32-bit preamble (N=64)      |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module mdio_arbiter #(
  parameter int unsigned CLK_DIV = 8,
  parameter logic [4:0]  PRTAD   = 5'd0
) (
  input  wire logic       clk_i,
  input  wire logic       reset_i,
  mdio_arbiter_if.slave   bus,
  output logic            mdc_o,
  output logic            mdio_o,
  output logic            mdio_oe_o,
  input  wire logic       mdio_i,
  output logic [2:0]      mdio_sel_o
);

`ifdef MDIO_PREAMBLE_EN
  localparam int unsigned N = 64;
`else
  localparam int unsigned N = 32;
`endif
  localparam logic [5:0] C_LAST_BIT = 6'(N - 1);
  localparam logic [5:0] C_TA_BIT   = 6'(N - 18);
  localparam logic [5:0] C_DATA_BIT = 6'(N - 16);
  localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t       state_q;
  logic [2:0]   ptr_q, sel_q;
  logic [1:0]   op_q;
  logic [N-1:0] shreg_q;
  logic [15:0]  rdata_q, rsp_data_q;
  logic [5:0]   bit_q;
  logic [7:0]   div_q, rsp_valid_q;
  logic         mdc_q, mdio_q, oe_q, busy_q;

  logic         w_found, w_grant;
  logic [2:0]   w_idx, w_cand;
  logic [5:0]   w_dv_base;
  logic [1:0]   w_op;
  logic [4:0]   w_devad;
  logic [15:0]  w_data;
  logic [31:0]  w_core;
  logic [N-1:0] w_frame;

  // First requesting lane at or after the pointer, wrapping 7 -> 0.
  always_comb begin
    w_found = 1'b0;
    w_idx   = ptr_q;
    w_cand  = ptr_q;
    for (int i = 0; i < 8; i++) begin
      w_cand = ptr_q + 3'(i);
      if (!w_found && bus.req_i[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
  end

  assign w_grant   = (state_q == IDLE) && w_found && !reset_i;
  assign w_dv_base = 6'(w_idx) * 6'd5;
  assign w_op      = bus.cmd_op_i[{w_idx, 1'b0} +: 2];
  assign w_devad   = bus.cmd_devad_i[w_dv_base +: 5];
  assign w_data    = bus.cmd_data_i[{w_idx, 4'b0000} +: 16];

  // Reads carry ones in TA/DATA so the released line idles high.
  assign w_core = w_op[1] ? {2'b00, w_op, PRTAD, w_devad, 2'b11, 16'hFFFF}
                          : {2'b00, w_op, PRTAD, w_devad, 2'b10, w_data};
`ifdef MDIO_PREAMBLE_EN
  assign w_frame = {32'hFFFF_FFFF, w_core};
`else
  assign w_frame = w_core;
`endif

  assign bus.gnt_o       = w_grant ? (8'd1 << w_idx) : 8'd0;
  assign mdio_sel_o      = w_grant ? w_idx : sel_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.busy_o      = busy_q;
  assign mdc_o           = mdc_q;
  assign mdio_o          = mdio_q;
  assign mdio_oe_o       = oe_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      sel_q       <= 3'd0;
      op_q        <= 2'b00;
      shreg_q     <= '0;
      rdata_q     <= 16'h0000;
      rsp_data_q  <= 16'h0000;
      rsp_valid_q <= 8'h00;
      bit_q       <= 6'd0;
      div_q       <= 8'd0;
      mdc_q       <= 1'b0;
      mdio_q      <= 1'b1;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rsp_valid_q <= 8'h00;
      case (state_q)
        IDLE: begin
          if (w_grant) begin
            state_q <= SHIFT;
            sel_q   <= w_idx;
            ptr_q   <= w_idx + 3'd1;
            op_q    <= w_op;
            shreg_q <= w_frame << 1;
            mdio_q  <= w_frame[N-1];
            oe_q    <= 1'b1;
            mdc_q   <= 1'b0;
            div_q   <= 8'd0;
            bit_q   <= 6'd0;
            rdata_q <= 16'h0000;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          // Capture on the first high cycle of each read DATA bit.
          if (mdc_q && (div_q == 8'd0) && op_q[1] && (bit_q >= C_DATA_BIT)) begin
            rdata_q <= {rdata_q[14:0], mdio_i};
          end
          if (div_q != C_DIV_LAST) begin
            div_q <= div_q + 8'd1;
          end else begin
            div_q <= 8'd0;
            if (!mdc_q) begin
              mdc_q <= 1'b1;
            end else if (bit_q == C_LAST_BIT) begin
              state_q     <= DONE;
              mdc_q       <= 1'b0;
              mdio_q      <= 1'b1;
              oe_q        <= 1'b0;
              rsp_valid_q <= 8'd1 << sel_q;
              rsp_data_q  <= op_q[1] ? rdata_q : 16'h0000;
            end else begin
              mdc_q   <= 1'b0;
              bit_q   <= bit_q + 6'd1;
              mdio_q  <= shreg_q[N-1];
              shreg_q <= shreg_q << 1;
              oe_q    <= !(op_q[1] && ((bit_q + 6'd1) >= C_TA_BIT));
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
